// File: rtl/multicycle_controller_pkg.sv
// control_defs: shared encodings for the multicycle MIPS controller,
// its datapath and benches.
//   - state_t: controller state codes (exposed on the debug state port)
//   - opcode / funct field values for the supported instructions
//   - select encodings for alu_op, reg_dst, wb_sel, alu_src_b, pc_src
package control_defs;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_LW_READ  = 4'd3,
        S_LW_WB    = 4'd4,
        S_SW_WRITE = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JR       = 4'd12,
        S_ILLEGAL  = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_SLT = 3'd3;

    localparam logic [1:0] REG_DST_RT  = 2'd0;
    localparam logic [1:0] REG_DST_RD  = 2'd1;
    localparam logic [1:0] REG_DST_R31 = 2'd2;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    localparam logic       SRC_A_PC   = 1'b0;
    localparam logic       SRC_A_REGA = 1'b1;

    localparam logic [1:0] SRC_B_REGB    = 2'd0;
    localparam logic [1:0] SRC_B_FOUR    = 2'd1;
    localparam logic [1:0] SRC_B_IMM     = 2'd2;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

    localparam logic       EXT_SIGN = 1'b0;
    localparam logic       EXT_ZERO = 1'b1;

    localparam logic       ADDR_PC     = 1'b0;
    localparam logic       ADDR_ALUOUT = 1'b1;

    localparam logic [1:0] PC_SRC_ALU     = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT  = 2'd1;
    localparam logic [1:0] PC_SRC_JTARGET = 2'd2;
    localparam logic [1:0] PC_SRC_REGA    = 2'd3;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle.
//   datapath -> controller: op, funct (decoded IR fields), zero (ALU flag)
//   controller -> datapath: write enables, mux selects, alu_op,
//                           retire, illegal, debug state
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;

    logic       pc_we;
    logic       ir_we;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wb_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_sel;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       retire;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  op, funct, zero,
        output pc_we, ir_we, mem_we, mem_addr_sel, reg_we, reg_dst, wb_sel,
               alu_src_a, alu_src_b, ext_sel, alu_op, pc_src, retire,
               illegal, state
    );

    modport slave (
        output op, funct, zero,
        input  pc_we, ir_we, mem_we, mem_addr_sel, reg_we, reg_dst, wb_sel,
               alu_src_a, alu_src_b, ext_sel, alu_op, pc_src, retire,
               illegal, state
    );
endinterface

// File: rtl/multicycle_controller_alu_control.sv
// alu_control: maps the R-type funct field to an ALU operation.
//   funct  in  6  instruction[5:0]
//   alu_op out 3  ADD for add and for any unrecognised funct, SUB, SLT
module alu_control
    import control_defs::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op
);
    always_comb begin
        alu_op = ALU_ADD;
        case (funct)
            FN_SUB:  alu_op = ALU_SUB;
            FN_SLT:  alu_op = ALU_SLT;
            default: alu_op = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM sequencing the multicycle MIPS
// datapath (one state per cycle; BNE's pc_we is the only Mealy output).
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset
//   bus    master modport: op/funct/zero in, all enables/selects out,
//          retire (last cycle of an instruction), illegal (sticky), state
module multicycle_controller
    import control_defs::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic                        clk,
    input  logic                        reset,
    multicycle_controller_if.master     bus
);
    state_t     state_q;
    state_t     state_d;
    logic [2:0] r_alu_op;

    alu_control u_alu_control (
        .funct  (bus.funct),
        .alu_op (r_alu_op)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= state_t'(RESET_STATE);
        else       state_q <= state_d;
    end

    assign bus.state = state_q;

    always_comb begin
        state_d          = S_ILLEGAL;
        bus.pc_we        = 1'b0;
        bus.ir_we        = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr_sel = ADDR_PC;
        bus.reg_we       = 1'b0;
        bus.reg_dst      = REG_DST_RT;
        bus.wb_sel       = WB_ALUOUT;
        bus.alu_src_a    = SRC_A_PC;
        bus.alu_src_b    = SRC_B_REGB;
        bus.ext_sel      = EXT_SIGN;
        bus.alu_op       = ALU_ADD;
        bus.pc_src       = PC_SRC_ALU;
        bus.retire       = 1'b0;
        bus.illegal      = 1'b0;

        case (state_q)
            S_FETCH: begin
                bus.ir_we     = 1'b1;
                bus.alu_src_b = SRC_B_FOUR;
                bus.pc_we     = 1'b1;
                state_d       = S_DECODE;
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut.
                bus.alu_src_b = SRC_B_IMM_SH2;
                case (bus.op)
                    OP_LW, OP_SW:     state_d = S_MEM_ADDR;
                    OP_RTYPE: begin
                        if (bus.funct == FN_JR)
                            state_d = S_JR;
                        else if (bus.funct == FN_ADD || bus.funct == FN_SUB ||
                                 bus.funct == FN_SLT)
                            state_d = S_R_EXEC;
                        else
                            state_d = S_ILLEGAL;
                    end
                    OP_ADDI, OP_XORI: state_d = S_I_EXEC;
                    OP_BNE:           state_d = S_BRANCH;
                    OP_J, OP_JAL:     state_d = S_JUMP;
                    default:          state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: begin
                bus.alu_src_a = SRC_A_REGA;
                bus.alu_src_b = SRC_B_IMM;
                state_d       = (bus.op == OP_LW) ? S_LW_READ : S_SW_WRITE;
            end
            S_LW_READ: begin
                bus.mem_addr_sel = ADDR_ALUOUT;
                state_d          = S_LW_WB;
            end
            S_LW_WB: begin
                bus.reg_we  = 1'b1;
                bus.reg_dst = REG_DST_RT;
                bus.wb_sel  = WB_MDR;
                bus.retire  = 1'b1;
                state_d     = S_FETCH;
            end
            S_SW_WRITE: begin
                bus.mem_addr_sel = ADDR_ALUOUT;
                bus.mem_we       = 1'b1;
                bus.retire       = 1'b1;
                state_d          = S_FETCH;
            end
            S_R_EXEC: begin
                bus.alu_src_a = SRC_A_REGA;
                bus.alu_op    = r_alu_op;
                state_d       = S_R_WB;
            end
            S_R_WB: begin
                bus.reg_we  = 1'b1;
                bus.reg_dst = REG_DST_RD;
                bus.retire  = 1'b1;
                state_d     = S_FETCH;
            end
            S_I_EXEC: begin
                bus.alu_src_a = SRC_A_REGA;
                bus.alu_src_b = SRC_B_IMM;
                if (bus.op == OP_XORI) begin
                    bus.ext_sel = EXT_ZERO;
                    bus.alu_op  = ALU_XOR;
                end
                state_d = S_I_WB;
            end
            S_I_WB: begin
                bus.reg_we = 1'b1;
                bus.retire = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a = SRC_A_REGA;
                bus.alu_op    = ALU_SUB;
                bus.pc_src    = PC_SRC_ALUOUT;
                bus.pc_we     = ~bus.zero;
                bus.retire    = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_src = PC_SRC_JTARGET;
                bus.pc_we  = 1'b1;
                bus.retire = 1'b1;
                // JAL links PC+4, which the PC still holds in this cycle.
                if (bus.op == OP_JAL) begin
                    bus.reg_we  = 1'b1;
                    bus.reg_dst = REG_DST_R31;
                    bus.wb_sel  = WB_PC;
                end
                state_d = S_FETCH;
            end
            S_JR: begin
                bus.pc_src = PC_SRC_REGA;
                bus.pc_we  = 1'b1;
                bus.retire = 1'b1;
                state_d    = S_FETCH;
            end
            S_ILLEGAL: begin
                bus.illegal = 1'b1;
                state_d     = S_ILLEGAL;
            end
            default: state_d = S_ILLEGAL;
        endcase

        // Reset suppresses every side effect of the state being aborted.
        if (reset) begin
            bus.pc_we   = 1'b0;
            bus.ir_we   = 1'b0;
            bus.mem_we  = 1'b0;
            bus.reg_we  = 1'b0;
            bus.retire  = 1'b0;
            bus.illegal = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    typedef enum int {
        K_LW, K_SW, K_J, K_JAL, K_JR, K_BNE, K_ADDI, K_XORI,
        K_ADD, K_SUB, K_SLT, K_ILL
    } kind_e;

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wb_sel;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_sel;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       retire;
        logic       illegal;
        logic [3:0] state;
    } ctl_t;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    multicycle_controller_if bus ();

    multicycle_controller #(.RESET_STATE(4'd0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Cycles from FETCH through the retiring cycle, by instruction class.
    function automatic int cpi(kind_e k);
        case (k)
            K_J, K_JAL, K_JR, K_BNE: return 3;
            K_LW:                    return 5;
            default:                 return 4;
        endcase
    endfunction

    // Expected controls for cycle `step` of an instruction of kind k.
    function automatic ctl_t expect_ctl(kind_e k, int step, logic z);
        ctl_t e = '0;
        if (step == 0) begin
            e.state = 4'd0; e.ir_we = 1; e.pc_we = 1; e.alu_src_b = 2'd1;
            return e;
        end
        if (step == 1) begin
            e.state = 4'd1; e.alu_src_b = 2'd3;
            return e;
        end
        case (k)
            K_LW, K_SW: begin
                if (step == 2) begin
                    e.state = 4'd2; e.alu_src_a = 1; e.alu_src_b = 2'd2;
                end else if (k == K_LW && step == 3) begin
                    e.state = 4'd3; e.mem_addr_sel = 1;
                end else if (k == K_LW) begin
                    e.state = 4'd4; e.reg_we = 1; e.wb_sel = 2'd1; e.retire = 1;
                end else begin
                    e.state = 4'd5; e.mem_addr_sel = 1; e.mem_we = 1; e.retire = 1;
                end
            end
            K_ADD, K_SUB, K_SLT: begin
                if (step == 2) begin
                    e.state = 4'd6; e.alu_src_a = 1;
                    e.alu_op = (k == K_SUB) ? 3'd1 : (k == K_SLT) ? 3'd3 : 3'd0;
                end else begin
                    e.state = 4'd7; e.reg_we = 1; e.reg_dst = 2'd1; e.retire = 1;
                end
            end
            K_ADDI, K_XORI: begin
                if (step == 2) begin
                    e.state = 4'd8; e.alu_src_a = 1; e.alu_src_b = 2'd2;
                    if (k == K_XORI) begin e.ext_sel = 1; e.alu_op = 3'd2; end
                end else begin
                    e.state = 4'd9; e.reg_we = 1; e.retire = 1;
                end
            end
            K_BNE: begin
                e.state = 4'd10; e.alu_src_a = 1; e.alu_op = 3'd1;
                e.pc_src = 2'd1; e.pc_we = ~z; e.retire = 1;
            end
            K_J, K_JAL: begin
                e.state = 4'd11; e.pc_src = 2'd2; e.pc_we = 1; e.retire = 1;
                if (k == K_JAL) begin e.reg_we = 1; e.reg_dst = 2'd2; e.wb_sel = 2'd2; end
            end
            K_JR: begin
                e.state = 4'd12; e.pc_src = 2'd3; e.pc_we = 1; e.retire = 1;
            end
            default: begin
                e.state = 4'd13; e.illegal = 1;
            end
        endcase
        return e;
    endfunction

    function automatic ctl_t mask_reset(ctl_t e);
        ctl_t m = e;
        m.pc_we = 0; m.ir_we = 0; m.mem_we = 0; m.reg_we = 0;
        m.retire = 0; m.illegal = 0;
        return m;
    endfunction

    function automatic bit supported_op(logic [5:0] op);
        return op == 6'h00 || op == 6'h02 || op == 6'h03 || op == 6'h05 ||
               op == 6'h08 || op == 6'h0e || op == 6'h23 || op == 6'h2b;
    endfunction

    task automatic pick_code(input kind_e k, output logic [5:0] op, output logic [5:0] fn);
        fn = 6'($urandom);
        case (k)
            K_LW:   op = 6'b100011;
            K_SW:   op = 6'b101011;
            K_J:    op = 6'b000010;
            K_JAL:  op = 6'b000011;
            K_JR:   begin op = 6'b000000; fn = 6'b001000; end
            K_BNE:  op = 6'b000101;
            K_ADDI: op = 6'b001000;
            K_XORI: op = 6'b001110;
            K_ADD:  begin op = 6'b000000; fn = 6'b100000; end
            K_SUB:  begin op = 6'b000000; fn = 6'b100010; end
            K_SLT:  begin op = 6'b000000; fn = 6'b101010; end
            default: begin
                if ($urandom_range(0, 1) == 0) begin
                    op = 6'b000000;
                    while (fn == 6'h08 || fn == 6'h20 || fn == 6'h22 || fn == 6'h2a)
                        fn = 6'($urandom);
                end else begin
                    op = 6'($urandom);
                    while (supported_op(op)) op = 6'($urandom);
                end
            end
        endcase
    endtask

    function automatic ctl_t observe();
        ctl_t o;
        o.pc_we = bus.pc_we;         o.ir_we = bus.ir_we;
        o.mem_we = bus.mem_we;       o.mem_addr_sel = bus.mem_addr_sel;
        o.reg_we = bus.reg_we;       o.reg_dst = bus.reg_dst;
        o.wb_sel = bus.wb_sel;       o.alu_src_a = bus.alu_src_a;
        o.alu_src_b = bus.alu_src_b; o.ext_sel = bus.ext_sel;
        o.alu_op = bus.alu_op;       o.pc_src = bus.pc_src;
        o.retire = bus.retire;       o.illegal = bus.illegal;
        o.state = bus.state;
        return o;
    endfunction

    // Called at posedge+1; samples at the falling edge, returns at next posedge+1.
    task automatic check_cycle(input ctl_t e, input string tag);
        ctl_t o;
        #4;
        o = observe();
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s got %h exp %h", tag, o, e);
        end
        @(posedge clk);
        #1;
    endtask

    // One instruction. zmode<0 randomises zero each cycle; abort_step>=0
    // asserts reset in that cycle. Illegal instructions sit 10 cycles in
    // the trap state and are then reset.
    task automatic run_instr(input kind_e k, input logic [5:0] op,
                             input logic [5:0] fn, input int zmode,
                             input int abort_step, input string tag);
        int   n     = (k == K_ILL) ? 13 : cpi(k);
        int   abort = (k == K_ILL) ? 12 : abort_step;
        ctl_t e;
        logic z;
        bus.op    = op;
        bus.funct = fn;
        for (int s = 0; s < n; s++) begin
            z = (zmode < 0) ? 1'($urandom) : 1'(zmode);
            bus.zero = z;
            reset = (s == abort);
            e = expect_ctl(k, (k == K_ILL && s > 2) ? 2 : s, z);
            if (reset) e = mask_reset(e);
            check_cycle(e, $sformatf("%s[%0d]", tag, s));
            if (s == abort) begin
                reset = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        kind_e      k;
        int         abort;

        reset     = 1'b1;
        bus.op    = '0;
        bus.funct = '0;
        bus.zero  = 1'b0;
        @(posedge clk);
        #1;
        check_cycle(mask_reset(expect_ctl(K_LW, 0, 1'b0)), "reset_state");
        reset = 1'b0;

        run_instr(K_LW,   6'b100011, 6'b010101, -1, -1, "lw");
        run_instr(K_SUB,  6'b000000, 6'b100010, -1, -1, "sub");
        run_instr(K_BNE,  6'b000101, 6'b000000,  1, -1, "bne_taken_no");
        run_instr(K_BNE,  6'b000101, 6'b000000,  0, -1, "bne_taken");
        run_instr(K_JAL,  6'b000011, 6'b111111, -1, -1, "jal");
        run_instr(K_XORI, 6'b001110, 6'b000000, -1, -1, "xori");
        run_instr(K_ILL,  6'b111111, 6'b000000, -1, -1, "illegal");
        run_instr(K_LW,   6'b100011, 6'b000000, -1,  3, "lw_abort");
        run_instr(K_SW,   6'b101011, 6'b000000, -1, -1, "sw_after_abort");
        run_instr(K_JR,   6'b000000, 6'b001000, -1, -1, "jr");

        for (int i = 0; i < 80; i++) begin
            k = kind_e'($urandom_range(0, 11));
            pick_code(k, op, fn);
            abort = ($urandom_range(0, 7) == 0) ? $urandom_range(0, cpi(k) - 1) : -1;
            run_instr(k, op, fn, -1, abort, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
